digit_entry_ctrl: RTL and testbench
===================================

// Module: digit_entry_ctrl
// PURPOSE
//  Sequences two-digit decimal entry from a keypad/switch front end: tens digit, then units digit.
//  Combines the digits into one binary value (0..99), range-checks it and offers it downstream
//  over a valid/ready handshake. Sits between the key debouncer/decoder and the consumer
//  (display driver or setpoint register), and owns clear, enter and inactivity-abort handling.
// PARAMETERS
//  MAX_VALUE       99           largest committable value (1..99); larger values are rejected
//  TIMEOUT_CYCLES  250_000_000  inactivity limit in CLOCK_50 cycles (5 s); used only with the macro
// PORTS
//  CLOCK_50     in   1  system clock, 50 MHz; all logic on posedge
//  reset        in   1  asynchronous, active-low
//  key_valid    in   1  one-cycle strobe: key_code is valid this cycle
//  key_code     in   4  0..9 digit; 4'hA CLEAR; 4'hB ENTER; 4'hC..4'hF ignored (no error)
//  entry_value  out  7  live partial value being typed (for echo display)
//  digit_count  out  2  digits accepted so far: 0, 1 or 2
//  out_value    out  7  committed value; stable while out_valid=1
//  out_valid    out  1  committed value offered downstream
//  out_ready    in   1  consumer accepts out_value when out_valid & out_ready
//  error        out  1  one-cycle pulse: illegal key for the state or value out of range
//  timeout      out  1  one-cycle pulse: entry aborted on inactivity (constant 0 without macro)
// BEHAVIOUR
//  Reset (reset=0, async): state=EMPTY; acc, entry_value, out_value=0; digit_count=0;
//   out_valid, error, timeout=0; inactivity counter=0. Reset mid-entry or mid-offer discards all.
//  Keys are sampled on the posedge where key_valid=1; results are visible after that edge (1 cycle).
//  entry_value=acc and digit_count={EMPTY:0, ONE:1, TWO:2, HOLD:last count} every cycle.
//  FSM:
//   EMPTY: digit d -> acc=d, ONE. ENTER -> error pulse, stay. CLEAR -> stay, acc=0.
//   ONE:   digit d -> acc=acc*10+d, TWO. ENTER -> commit acc (one digit = units value).
//          CLEAR -> acc=0, EMPTY.
//   TWO:   digit -> error pulse, ignored (no shift-out). ENTER -> commit. CLEAR -> acc=0, EMPTY.
//   HOLD:  out_valid=1, out_value held. All keys ignored (no error). On out_valid & out_ready:
//          out_valid=0, acc=0, EMPTY in the following cycle.
//  Commit: if acc<=MAX_VALUE then out_value=acc, out_valid=1, HOLD; else error pulse, acc=0, EMPTY.
//  Arithmetic: acc is 7 bits unsigned; acc*10+d is at most 99, so no overflow; compute the multiply
//   as (acc<<3)+(acc<<1)+d.
//  Handshake: out_valid never drops without out_ready; out_value never changes while out_valid=1.
//   If out_ready is held high, a commit handshakes on the first HOLD cycle.
//  error and timeout are single-cycle pulses and never assert in the same cycle.
// CONFIGURATION
//  ENTRY_TIMEOUT_EN defined: in ONE/TWO, a 28-bit counter increments every cycle and clears on
//   every accepted key_valid (including ignored codes) and on any state change. When the counter
//   reaches TIMEOUT_CYCLES-1: acc=0, EMPTY, timeout pulse. If key_valid arrives in the expiry
//   cycle, the key wins: it is processed and the counter clears. No counting in EMPTY/HOLD.
//  ENTRY_TIMEOUT_EN undefined: no counter logic; timeout tied to 0; entry waits indefinitely.
// TESTING
//  1. keys 4,2,ENTER with out_ready=1 -> entry_value 4 then 42; out_value=42, out_valid 1 cycle; EMPTY.
//  2. keys 7,ENTER with out_ready=0 for 10 cycles -> out_value=7 and out_valid held steady;
//     keys 1,2 during HOLD are ignored; after out_ready, digit_count=0.
//  3. MAX_VALUE=59; keys 6,5,ENTER -> error pulse, no out_valid, entry_value=0; then keys 5,9,ENTER -> 59.
//  4. keys 3,8,1 -> error on the third digit, entry_value stays 38; CLEAR -> entry_value 0, digit_count 0;
//     ENTER in EMPTY -> error.
//  5. TIMEOUT_CYCLES=16 with the macro: key 5, idle 16 cycles -> timeout pulse, EMPTY; key in the expiry
//     cycle is processed instead. Without the macro, idle 1000 cycles -> still ONE, timeout=0.
//  6. Pull reset low mid-HOLD and mid-TWO (asynchronously, between edges) -> all outputs 0 at once.

Source files
------------

// File: rtl/digit_entry_ctrl.sv
// Two-digit decimal entry sequencer: results appear 1 cycle after the key edge; out_value is held until out_ready.
// Defining ENTRY_TIMEOUT_EN adds an inactivity abort of a half-typed entry after TIMEOUT_CYCLES idle cycles.
module digit_entry_ctrl #(
  parameter int MAX_VALUE      = 99,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [6:0] entry_value,
  output logic [1:0] digit_count,
  output logic [6:0] out_value,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       error,
  output logic       timeout
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO, HOLD} state_t;

  localparam logic [6:0] MAX_V = 7'(MAX_VALUE);

  state_t     state_q, state_d;
  logic [6:0] acc_q, acc_d;
  logic [6:0] out_value_q, out_value_d;
  logic [1:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic       error_q, error_d;

  logic is_digit, is_clear, is_enter, fits, expire;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clear = key_valid && (key_code == 4'hA);
  assign is_enter = key_valid && (key_code == 4'hB);
  assign fits     = (acc_q <= MAX_V);

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [27:0] TMO_LAST = 28'(TIMEOUT_CYCLES - 1);

  logic [27:0] idle_q, idle_d;
  logic        timeout_q;
  logic        entering;

  assign entering = (state_q == ONE) || (state_q == TWO);
  // A key in the expiry cycle takes priority over the abort.
  assign expire   = entering && !key_valid && (idle_q == TMO_LAST);

  always_comb begin
    idle_d = idle_q + 28'd1;
    if (key_valid || !entering || (state_d != state_q)) begin
      idle_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= expire;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign expire             = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    error_d     = 1'b0;

    unique case (state_q)
      EMPTY: begin
        if (is_digit) begin
          acc_d   = {3'b000, key_code};
          state_d = ONE;
        end else if (is_enter) begin
          error_d = 1'b1;
        end else if (is_clear) begin
          acc_d = '0;
        end
      end
      ONE, TWO: begin
        if (is_digit) begin
          if (state_q == ONE) begin
            acc_d   = (acc_q << 3) + (acc_q << 1) + {3'b000, key_code};
            state_d = TWO;
          end else begin
            error_d = 1'b1;
          end
        end else if (is_enter) begin
          if (fits) begin
            out_value_d = acc_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            error_d = 1'b1;
            acc_d   = '0;
            state_d = EMPTY;
          end
        end else if (is_clear || expire) begin
          acc_d   = '0;
          state_d = EMPTY;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    unique case (state_d)
      EMPTY:   cnt_d = 2'd0;
      ONE:     cnt_d = 2'd1;
      TWO:     cnt_d = 2'd2;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      out_value_q <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_value_q <= out_value_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
    end
  end

  assign entry_value = acc_q;
  assign digit_count = cnt_q;
  assign out_value   = out_value_q;
  assign out_valid   = out_valid_q;
  assign error       = error_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Bench for digit_entry_ctrl: directed scenarios plus random keys checked against a digit-list reference model.
module tb_digit_entry_ctrl;

  localparam int MAXV = 59;
  localparam int TMO  = 16;

  logic       CLOCK_50;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [6:0] entry_value;
  logic [1:0] digit_count;
  logic [6:0] out_value;
  logic       out_valid;
  logic       out_ready;
  logic       error;
  logic       timeout;

  digit_entry_ctrl #(.MAX_VALUE(MAXV), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .entry_value(entry_value),
    .digit_count(digit_count),
    .out_value  (out_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .error      (error),
    .timeout    (timeout)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: the digits typed so far, plus an offer in progress.
  int digs[$];
  bit holding  = 1'b0;
  int held_val = 0;
  int idle     = 0;
  bit exp_err  = 1'b0;
  bit exp_to   = 1'b0;

  function automatic int digs_value();
    int v = 0;
    foreach (digs[i]) v = v * 10 + digs[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    digs.delete();
    holding  = 1'b0;
    held_val = 0;
    idle     = 0;
    exp_err  = 1'b0;
    exp_to   = 1'b0;
  endtask

  task automatic model(input bit kv, input logic [3:0] kc, input bit rdy);
    int v;
    exp_err = 1'b0;
    exp_to  = 1'b0;
    if (holding) begin
      if (rdy) begin
        holding = 1'b0;
        digs.delete();
      end
    end else if (kv) begin
      idle = 0;
      if (kc <= 4'd9) begin
        if (digs.size() < 2) digs.push_back(int'(kc));
        else exp_err = 1'b1;
      end else if (kc == 4'hA) begin
        digs.delete();
      end else if (kc == 4'hB) begin
        v = digs_value();
        if (digs.size() == 0) exp_err = 1'b1;
        else if (v <= MAXV) begin
          holding  = 1'b1;
          held_val = v;
        end else begin
          exp_err = 1'b1;
          digs.delete();
        end
      end
    end else if (digs.size() > 0) begin
`ifdef ENTRY_TIMEOUT_EN
      if (idle == TMO - 1) begin
        digs.delete();
        exp_to = 1'b1;
        idle   = 0;
      end else begin
        idle++;
      end
`endif
    end
  endtask

  task automatic check_all();
    chk("entry_value", entry_value, digs_value());
    chk("digit_count", digit_count, digs.size());
    chk("out_valid", out_valid, holding);
    if (holding) chk("out_value", out_value, held_val);
    chk("error", error, exp_err);
    chk("timeout", timeout, exp_to);
  endtask

  task automatic step(input bit kv, input logic [3:0] kc, input bit rdy);
    @(negedge CLOCK_50);
    key_valid = kv;
    key_code  = kc;
    out_ready = rdy;
    @(posedge CLOCK_50);
    model(kv, kc, rdy);
    #1 check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_entry_value"}, entry_value, 0);
    chk({tag, "_digit_count"}, digit_count, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_value"}, out_value, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge CLOCK_50);
    #3 reset = 1'b0;
    key_valid = 1'b0;
    #1 check_zero(tag);
    model_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
  endtask

  initial begin
    int r;
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    out_ready = 1'b0;
    model_reset();
    #23 check_zero("reset");
    @(negedge CLOCK_50);
    reset = 1'b1;

    // 42 with the consumer always ready
    step(1, 4'd4, 1); step(1, 4'd2, 1); step(1, 4'hB, 1); step(0, 4'd0, 1); step(0, 4'd0, 1);

    // 7 held while the consumer stalls; digits during the offer are ignored
    step(1, 4'd7, 0); step(1, 4'hB, 0);
    for (int i = 0; i < 10; i++) step(i == 2 || i == 5, (i == 2) ? 4'd1 : 4'd2, 0);
    step(0, 4'd0, 1); step(0, 4'd0, 0);
    chk("after_release_count", digit_count, 0);

    // out of range, then the largest legal value
    step(1, 4'd6, 0); step(1, 4'd5, 0); step(1, 4'hB, 0);
    step(1, 4'd5, 1); step(1, 4'd9, 1); step(1, 4'hB, 1); step(0, 4'd0, 1);

    // third digit, clear, enter on empty, ignored codes
    step(1, 4'd3, 0); step(1, 4'd8, 0); step(1, 4'd1, 0);
    step(1, 4'hA, 0); step(1, 4'hB, 0); step(1, 4'hC, 0); step(1, 4'hF, 0);

    // inactivity
    step(1, 4'd5, 0);
`ifdef ENTRY_TIMEOUT_EN
    repeat (TMO) step(0, 4'd0, 0);
    chk("timeout_empty", digit_count, 0);
    step(1, 4'd5, 0);
    repeat (TMO - 1) step(0, 4'd0, 0);
    step(1, 4'd3, 0);
    chk("expiry_key_wins", entry_value, 53);
    step(1, 4'hA, 0);
`else
    repeat (1000) step(0, 4'd0, 0);
    chk("no_timeout_count", digit_count, 1);
    chk("no_timeout_pulse", timeout, 0);
    step(1, 4'hA, 0);
`endif

    // asynchronous reset mid-offer and mid-entry
    step(1, 4'd4, 0); step(1, 4'd2, 0); step(1, 4'hB, 0); step(0, 4'd0, 0);
    async_reset("rst_hold");
    step(1, 4'd1, 0); step(1, 4'd2, 0);
    async_reset("rst_two");

    // random keys against the model, with occasional idle stretches
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 250) begin
        step(1, 4'($urandom_range(0, 9)), 0);
        repeat (TMO + 4) step(0, 4'd0, 0);
      end
      r = $urandom_range(0, 19);
      step($urandom_range(0, 1) == 1, (r > 15) ? 4'hB : 4'(r), $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
